clk_en_hub: RTL and testbench
=============================

CLK_EN_HUB -- requirements
Module: clk_en_hub

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent output channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of each channel's divide ratio and phase counter.
REQ-003 SHALL have parameter DEF_DIV, default 10, divide ratio loaded into every channel at reset (2..2^CNT_W-1).
REQ-004 SHALL have parameter CASCADE, default 0: 0 = every channel counts hub_clk cycles; 1 = channel i>0 counts ticks of channel i-1.
REQ-005 SHALL have port hub_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port hub_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port ch_en  in  N_CH  per-channel run enable.
REQ-008 SHALL have port sync  in  1  single-cycle request to realign all channels to phase 0.
REQ-009 SHALL have port cfg_wr  in  1  single-cycle divide-ratio write strobe.
REQ-010 SHALL have port cfg_ch  in  max(1,clog2(N_CH))  target channel index of cfg_wr.
REQ-011 SHALL have port cfg_div  in  CNT_W  new divide ratio for cfg_ch.
REQ-012 SHALL have port cfg_err  out  1  one-cycle pulse: last cfg_wr rejected.
REQ-013 SHALL have port cfg_pend  out  N_CH  per-channel flag: written ratio not yet applied.
REQ-014 SHALL have port tick  out  N_CH  one-cycle enable pulse per channel period.
REQ-015 SHALL have port clk_out  out  N_CH  square wave per channel, period = channel period.

Function
REQ-016 SHALL keep per channel: active ratio div, shadow ratio shd, phase counter cnt (0..div-1), started flag; all outputs registered.
REQ-017 SHALL, per channel step (every hub_clk cycle when CASCADE=0; for CASCADE=1, ch0 every cycle, ch i>0 only in cycles where tick[i-1]=1), advance cnt by 1; cnt==div-1 wraps to 0.
REQ-018 SHALL assert tick[i] for exactly the cycle following the edge on which cnt wraps to 0; period = div steps.
REQ-019 SHALL set started on first wrap; clk_out[i]=1 while started and cnt<ceil(div/2), else 0 (odd div: high one cycle longer than low).
REQ-020 SHALL, with ch_en[i]=0, force cnt=0, started=0, tick[i]=0, clk_out[i]=0 from the next edge; re-enable counts from phase 0 (first tick after div steps).
REQ-021 SHALL, on cfg_wr with cfg_div>=2 and cfg_ch<N_CH, load shd and set cfg_pend[cfg_ch] next cycle.
REQ-022 SHALL copy shd to div and clear cfg_pend only on that channel's wrap, or on sync, or while ch_en=0 (glitch-free retune; current period completes at old ratio).
REQ-023 SHALL, on cfg_wr with cfg_div<2 or cfg_ch>=N_CH, leave all state unchanged and pulse cfg_err one cycle later.
REQ-024 SHALL let a second cfg_wr to a pending channel overwrite shd; only the last value is applied.
REQ-025 SHALL, on sync=1, set every cnt=0 and started=0 next edge, clear tick and clk_out, apply all pending shd; sync has priority over wrap and cfg_wr apply in the same cycle; a cfg_wr in the sync cycle is still stored and pended.
REQ-026 SHALL, in CASCADE=1 with channel i-1 disabled, hold channel i at its current phase (no steps) while ch_en[i]=1.
REQ-027 SHALL use CNT_W-bit unsigned compare for all counters; no overflow beyond div-1.

Reset
REQ-028 SHALL, while hub_rst=1, set div=shd=DEF_DIV, cnt=0, started=0, cfg_pend=0, tick=0, clk_out=0, cfg_err=0 on every channel.
REQ-029 SHALL give hub_rst priority over sync, cfg_wr and ch_en; reset mid-period discards the phase and any pending ratio.

Verification
REQ-030 SHALL cover: N_CH=4, DEF_DIV=10, CASCADE=0, all ch_en=1 after reset -> tick every 10 cycles, first 10 cycles after reset release; clk_out 5 high/5 low.
REQ-031 SHALL cover: cfg_wr ch1 div=5 at mid-period (cnt=3) -> cfg_pend[1]=1 until wrap; period finishes at 10, then ticks every 5, clk_out 3 high/2 low, no runt pulse.
REQ-032 SHALL cover: cfg_wr div=1 and cfg_wr cfg_ch=4 -> cfg_err pulses once each, tick timing unchanged.
REQ-033 SHALL cover: CASCADE=1, DEF_DIV=10 -> ch1 ticks every 100, ch2 every 1000 cycles; ch0 disabled -> ch1 frozen at current phase.
REQ-034 SHALL cover: sync with ch2 pending ratio 7 -> all cnt=0, tick/clk_out low next cycle, ch2 ticks every 7 thereafter, all channels aligned.
REQ-035 SHALL cover: hub_rst during pending write and mid-period -> all outputs 0, ratios back to 10, first tick 10 cycles after release.

Source files
------------

// File: rtl/clk_en_hub.sv
// Clock-enable hub: N_CH programmable dividers producing tick pulses and
// square waves, with glitch-free retune, global phase sync and optional
// cascading where each channel counts ticks of the previous one.
module clk_en_hub #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 10,
  parameter int unsigned CASCADE = 0,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             hub_clk,
  input  logic             hub_rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [N_CH-1:0]  cfg_pend,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out
);

  localparam logic [CNT_W-1:0] DEF_V  = CNT_W'(DEF_DIV);
  localparam logic [CH_W:0]    N_CH_V = (CH_W+1)'(N_CH);

  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [CNT_W-1:0] shd_q [N_CH];
  logic [CNT_W-1:0] shd_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W:0]   half_c [N_CH];

  logic [N_CH-1:0] started_q, started_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] tick_q, tick_d;
  logic [N_CH-1:0] clk_q, clk_d;
  logic [N_CH-1:0] step_c;
  logic            err_q;
  logic            wr_bad_c;
  logic            wr_ok_c;

  // Step source: every cycle, or in cascade mode the previous channel's tick.
  if (CASCADE != 0 && N_CH > 1) begin : g_casc
    assign step_c = {tick_q[N_CH-2:0], 1'b1};
  end else begin : g_flat
    assign step_c = '1;
  end

  // A write is rejected for a ratio below 2 or a channel index out of range.
  assign wr_bad_c = cfg_wr && ((cfg_div < CNT_W'(2)) || ({1'b0, cfg_ch} >= N_CH_V));
  assign wr_ok_c  = cfg_wr && !wr_bad_c;

  // Per-channel next state: sync/disable realign, wrap applies shadow ratio.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      div_d[i]     = div_q[i];
      shd_d[i]     = shd_q[i];
      cnt_d[i]     = cnt_q[i];
      started_d[i] = started_q[i];
      pend_d[i]    = pend_q[i];
      tick_d[i]    = 1'b0;

      if (sync || !ch_en[i]) begin
        cnt_d[i]     = '0;
        started_d[i] = 1'b0;
        if (pend_q[i]) begin
          div_d[i]  = shd_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (step_c[i]) begin
        if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
          cnt_d[i]     = '0;
          started_d[i] = 1'b1;
          tick_d[i]    = 1'b1;
          if (pend_q[i]) begin
            div_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      // A write landing this cycle is held in the shadow for the next apply.
      if (wr_ok_c && (cfg_ch == CH_W'(i))) begin
        shd_d[i]  = cfg_div;
        pend_d[i] = 1'b1;
      end

      // High for the first ceil(div/2) phases once the channel has started.
      half_c[i] = ({1'b0, div_d[i]} + (CNT_W+1)'(1)) >> 1;
      clk_d[i]  = started_d[i] && ({1'b0, cnt_d[i]} < half_c[i]);
    end
  end

  // State registers with synchronous reset to the default ratio.
  always_ff @(posedge hub_clk) begin
    if (hub_rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        div_q[i] <= DEF_V;
        shd_q[i] <= DEF_V;
        cnt_q[i] <= '0;
      end
      started_q <= '0;
      pend_q    <= '0;
      tick_q    <= '0;
      clk_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      shd_q     <= shd_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_q     <= clk_d;
      err_q     <= wr_bad_c;
    end
  end

  assign cfg_err  = err_q;
  assign cfg_pend = pend_q;
  assign tick     = tick_q;
  assign clk_out  = clk_q;

endmodule

// File: tb/tb_clk_en_hub.sv
// Scoreboard bench for clk_en_hub: a flat 4-channel hub and a cascaded
// 3-channel hub driven side by side against a behavioural model.
module tb_clk_en_hub;

  logic       hub_clk = 1'b0;
  logic       hub_rst = 1'b1;
  logic [3:0] ch_en0  = 4'hF;
  logic [2:0] ch_en1  = 3'h7;
  logic       sync0   = 1'b0;
  logic       sync1   = 1'b0;
  logic       cfg_wr0 = 1'b0;
  logic       cfg_wr1 = 1'b0;
  logic [1:0] cfg_ch  = 2'd0;
  logic [15:0] cfg_div = 16'd0;

  logic       err0, err1;
  logic [3:0] pend0, tick0, clk0;
  logic [2:0] pend1, tick1, clk1;

  always #5 hub_clk = ~hub_clk;

  clk_en_hub #(.N_CH(4), .CNT_W(16), .DEF_DIV(10), .CASCADE(0)) u_flat (
    .hub_clk(hub_clk), .hub_rst(hub_rst), .ch_en(ch_en0), .sync(sync0),
    .cfg_wr(cfg_wr0), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_err(err0), .cfg_pend(pend0), .tick(tick0), .clk_out(clk0));

  clk_en_hub #(.N_CH(3), .CNT_W(16), .DEF_DIV(10), .CASCADE(1)) u_casc (
    .hub_clk(hub_clk), .hub_rst(hub_rst), .ch_en(ch_en1), .sync(sync1),
    .cfg_wr(cfg_wr1), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_err(err1), .cfg_pend(pend1), .tick(tick1), .clk_out(clk1));

  typedef struct packed {
    logic [3:0] tick0, clk0, pend0;
    logic       err0;
    logic [2:0] tick1, clk1, pend1;
    logic       err1;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  exp_t drv_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state per hub (0 = flat, 1 = cascaded), per channel.
  int m_div [2][4];
  int m_shd [2][4];
  int m_ph  [2][4];
  bit m_st  [2][4];
  bit m_pend[2][4];
  bit m_tk  [2][4];
  bit m_ck  [2][4];
  bit m_err [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // One hub step from the rules: count phases modulo the ratio, pulse on
  // return to phase 0, square wave high for the first half (rounded up).
  task automatic model_hub(input int h, input int n, input bit casc, input bit sy,
                           input logic [3:0] en, input bit wr);
    bit old_tk [4];
    bit stp, bad, wrap;
    for (int i = 0; i < 4; i++) old_tk[i] = m_tk[h][i];
    if (hub_rst) begin
      for (int i = 0; i < 4; i++) begin
        m_div[h][i] = 10; m_shd[h][i] = 10; m_ph[h][i] = 0;
        m_st[h][i] = 0; m_pend[h][i] = 0; m_tk[h][i] = 0; m_ck[h][i] = 0;
      end
      m_err[h] = 0;
    end else begin
      bad = wr && (int'(cfg_div) < 2 || int'(cfg_ch) >= n);
      for (int i = 0; i < n; i++) begin
        stp = 1'b1;
        if (casc && i > 0) stp = old_tk[i-1];
        wrap = 1'b0;
        if (sy || !en[i]) begin
          m_ph[h][i] = 0;
          m_st[h][i] = 0;
          if (m_pend[h][i]) begin m_div[h][i] = m_shd[h][i]; m_pend[h][i] = 0; end
        end else if (stp) begin
          m_ph[h][i] = (m_ph[h][i] + 1) % m_div[h][i];
          if (m_ph[h][i] == 0) begin
            wrap = 1'b1;
            m_st[h][i] = 1;
            if (m_pend[h][i]) begin m_div[h][i] = m_shd[h][i]; m_pend[h][i] = 0; end
          end
        end
        if (wr && !bad && int'(cfg_ch) == i) begin
          m_shd[h][i] = int'(cfg_div);
          m_pend[h][i] = 1;
        end
        m_tk[h][i] = wrap;
        m_ck[h][i] = m_st[h][i] && (m_ph[h][i] < (m_div[h][i] + 1) / 2);
      end
      m_err[h] = bad;
    end
  endtask

  // Advance one edge: model consumes the inputs that edge sampled, then queue.
  task automatic cycle();
    @(posedge hub_clk);
    #1;
    model_hub(0, 4, 1'b0, sync0, ch_en0, cfg_wr0);
    model_hub(1, 3, 1'b1, sync1, {1'b0, ch_en1}, cfg_wr1);
    for (int i = 0; i < 4; i++) begin
      drv_e.tick0[i] = m_tk[0][i];
      drv_e.clk0[i]  = m_ck[0][i];
      drv_e.pend0[i] = m_pend[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      drv_e.tick1[i] = m_tk[1][i];
      drv_e.clk1[i]  = m_ck[1][i];
      drv_e.pend1[i] = m_pend[1][i];
    end
    drv_e.err0 = m_err[0];
    drv_e.err1 = m_err[1];
    exp_q.push_back(drv_e);
  endtask

  // Monitor: compare every registered output against the queued expectation.
  always @(negedge hub_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("flat_tick", 32'(tick0), 32'(mon_e.tick0));
      chk("flat_clk",  32'(clk0),  32'(mon_e.clk0));
      chk("flat_pend", 32'(pend0), 32'(mon_e.pend0));
      chk("flat_err",  32'(err0),  32'(mon_e.err0));
      chk("casc_tick", 32'(tick1), 32'(mon_e.tick1));
      chk("casc_clk",  32'(clk1),  32'(mon_e.clk1));
      chk("casc_pend", 32'(pend1), 32'(mon_e.pend1));
      chk("casc_err",  32'(err1),  32'(mon_e.err1));
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) cycle();
    chk("rst_tick0", 32'(tick0), 0);
    chk("rst_clk0",  32'(clk0),  0);
    chk("rst_pend0", 32'(pend0), 0);
    chk("rst_err0",  32'(err0),  0);
    chk("rst_tick1", 32'(tick1), 0);
    hub_rst = 1'b0;

    for (int c = 1; c <= 6000; c++) begin
      cfg_wr0 = 1'b0; cfg_wr1 = 1'b0; sync0 = 1'b0; sync1 = 1'b0; hub_rst = 1'b0;
      if (c <= 2300) begin
        ch_en0 = 4'hF;
        ch_en1 = (c >= 2011 && c <= 2160) ? 3'b110 : 3'b111;
        case (c)
          24:   begin cfg_wr0 = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5; end
          42:   begin cfg_wr0 = 1'b1; cfg_wr1 = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd1; end
          44:   begin cfg_wr1 = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd5; end
          46:   begin cfg_wr0 = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0; end
          52:   begin cfg_wr0 = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd7; end
          55:   sync0 = 1'b1;
          2201: begin cfg_wr0 = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3; end
          2204, 2205: hub_rst = 1'b1;
          default: ;
        endcase
      end else begin
        hub_rst = ($urandom % 500) == 0;
        sync0   = ($urandom % 97) == 0;
        sync1   = ($urandom % 211) == 0;
        if (($urandom % 40) == 0) ch_en0 = 4'($urandom);
        if (($urandom % 40) == 0) ch_en1 = 3'($urandom);
        cfg_wr0 = ($urandom % 13) == 0;
        cfg_wr1 = ($urandom % 17) == 0;
        cfg_ch  = 2'($urandom % 4);
        cfg_div = 16'($urandom % 14);
      end

      cycle();

      case (c)
        9:    begin chk("first_tick_early", 32'(tick0), 0); chk("clk_before_start", 32'(clk0), 0); end
        10:   begin chk("first_tick", 32'(tick0), 4'hF); chk("clk_start", 32'(clk0), 4'hF);
                    chk("casc_ch0_tick", 32'(tick1), 3'b001); end
        11:   chk("tick_one_cycle", 32'(tick0), 0);
        14:   chk("clk_high_last", 32'(clk0), 4'hF);
        15:   chk("clk_low_first", 32'(clk0), 0);
        24:   chk("pend_set", 32'(pend0), 4'b0010);
        29:   begin chk("pend_held", 32'(pend0), 4'b0010); chk("old_period_runs", 32'(tick0), 0); end
        30:   begin chk("pend_cleared", 32'(pend0), 0); chk("old_period_end", 32'(tick0), 4'hF); end
        32:   chk("div5_high", 32'(clk0), 4'hF);
        33:   chk("div5_low", 32'(clk0), 4'b1101);
        35:   begin chk("div5_tick", 32'(tick0), 4'b0010); chk("div5_clk", 32'(clk0), 4'b0010); end
        40:   chk("tick_40", 32'(tick0), 4'hF);
        42:   begin chk("err_div1_flat", 32'(err0), 1); chk("err_div1_casc", 32'(err1), 1); end
        43:   begin chk("err_pulse_flat", 32'(err0), 0); chk("err_pulse_casc", 32'(err1), 0); end
        44:   begin chk("err_ch_range", 32'(err1), 1); chk("err_no_wr", 32'(err0), 0); end
        45:   chk("tick_after_err", 32'(tick0), 4'b0010);
        46:   begin chk("err_div0", 32'(err0), 1); chk("no_pend_on_err", 32'(pend0), 0); end
        50:   chk("tick_50", 32'(tick0), 4'hF);
        52:   chk("pend_ch2", 32'(pend0), 4'b0100);
        55:   begin chk("sync_tick", 32'(tick0), 0); chk("sync_clk", 32'(clk0), 0);
                    chk("sync_apply", 32'(pend0), 0); end
        60:   chk("sync_div5", 32'(tick0), 4'b0010);
        62:   chk("sync_div7", 32'(tick0), 4'b0100);
        65:   chk("sync_div10", 32'(tick0), 4'b1011);
        69:   chk("div7_again", 32'(tick0), 4'b0100);
        100:  chk("casc_100", 32'(tick1), 3'b001);
        101:  chk("casc_ch1", 32'(tick1), 3'b010);
        1001: chk("casc_ch1_1001", 32'(tick1), 3'b010);
        1002: chk("casc_ch2", 32'(tick1), 3'b100);
        2002: chk("casc_ch2_2002", 32'(tick1), 3'b100);
        2101: begin chk("frozen_tick", 32'(tick1), 0); chk("frozen_clk", 32'(clk1), 3'b110); end
        2201: chk("pend_before_rst", 32'(pend0), 4'b0001);
        2205: begin chk("midrst_tick", 32'(tick0), 0); chk("midrst_clk", 32'(clk0), 0);
                    chk("midrst_pend", 32'(pend0), 0); chk("midrst_casc", 32'({tick1, clk1}), 0); end
        2208: chk("no_div3_after_rst", 32'(tick0), 0);
        2214: chk("rst_tick_early", 32'(tick0), 0);
        2215: begin chk("rst_first_tick", 32'(tick0), 4'hF); chk("rst_casc_tick", 32'(tick1), 3'b001); end
        2225: chk("rst_div10", 32'(tick0), 4'hF);
        default: ;
      endcase
    end

    @(negedge hub_clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
